regfile_write_scheduler: RTL
============================

# regfile_write_scheduler

Shares the single write port of `register_array` between two write-back requesters: port A for ALU results and port B for load data. It also keeps a pending-write scoreboard so the issue stage can detect read-after-write hazards on the two read ports. Sits between the execute/memory stages and `register_array`. It drives `write_reg_address`, `write_data`, `write_word_enable` and `write_byte_enable` directly.

## Interface
- `REG_NUM`, 32, number of architectural registers
- `REG_WIDTH`, 32, data width
- `ADDR_WIDTH`, 5, register address width; must equal $clog2(REG_NUM)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `hold`  in  1  blocks all new grants while high
- `a_valid` / `b_valid`  in  1  requester has a write pending
- `a_ready` / `b_ready`  out  1  grant; handshake = valid & ready on a rising edge
- `a_addr` / `b_addr`  in  ADDR_WIDTH  destination register
- `a_data` / `b_data`  in  REG_WIDTH  write data
- `a_byte` / `b_byte`  in  1  1 = byte write, 0 = word write
- `reserve_valid`  in  1  issue stage claims a destination register
- `reserve_addr`  in  ADDR_WIDTH  register being claimed
- `reserve_err`  out  1  one-cycle pulse: claim hit an already-pending register
- `rd1_addr` / `rd2_addr`  in  ADDR_WIDTH  read addresses to check
- `rd1_pending` / `rd2_pending`  out  1  combinational scoreboard lookup
- `write_reg_address`  out  ADDR_WIDTH  to register_array
- `write_data`  out  REG_WIDTH  to register_array
- `write_word_enable` / `write_byte_enable`  out  1  to register_array; never both high

## Operation
- Arbiter state is a 1-bit priority pointer `prio`:
  - PRIO_A: A wins ties.
  - PRIO_B: B wins ties.
- Grant rules (combinational): with `hold` = 0, exactly one ready is asserted when at least one valid is high. The lone valid requester is always granted.
- `prio` flips only on a tie (both valid, one granted). It moves to the other requester. A lone grant leaves `prio` unchanged.
- `ready` does not depend on `ready`. A requester must hold addr, data and byte stable while valid and not yet granted.
- Output register:
  - On handshake, latch addr and data.
  - Set `write_byte_enable` = byte and `write_word_enable` = !byte.
  - With no handshake, both enables are 0. Address and data hold their last value.
- Scoreboard: REG_NUM-bit vector `pending`.
  - `reserve_valid` sets `pending[reserve_addr]`.
  - A write presented on the outputs (either enable high) clears `pending[write_reg_address]` on the edge that ends that cycle. This is the same edge on which `register_array` captures the data.
  - Reserve and clear of the same address on the same edge: reserve wins, bit stays 1.
  - Reserve of an address whose bit is already 1 and not being cleared that edge: bit stays 1 and `reserve_err` pulses for one cycle.
- Register 0 gets no special treatment.
- `rd*_pending` = `pending[rd*_addr]`, purely combinational.

## Timing
- Throughput: one write per cycle sustained.
- Latency: handshake at edge E0 → enables high during cycle E0..E1 → data in the array after E1 → `pending` bit clear after E1.
- `hold` rising: no grant in the same cycle. A write already in the output register still completes.
- Reset (`rst` low, asynchronous), immediately:
  - `write_*_enable` = 0, `write_reg_address` = 0, `write_data` = 0
  - `pending` = 0, `prio` = PRIO_A, `reserve_err` = 0
- A write in flight when reset asserts is dropped.
- After `rst` deasserts, grants start on the first rising edge with valid high.

## Structure
- Package `regfile_pkg`:
  - `ADDR_WIDTH`
  - `prio_t` enum {PRIO_A, PRIO_B}
  - `wr_kind_t` enum {WR_NONE, WR_WORD, WR_BYTE}
- Sub-module `wb_rr_arbiter`: 2-way round-robin arbiter holding `prio`, with inputs valids and `hold`, output grants.
- Top level: output register, scoreboard, `reserve_err` logic.

## Test plan
- **Reset:** pulse `rst` low mid-cycle → all outputs 0 within the same cycle, `rd1_pending` = 0 for every address.
- **Single write:** `a_valid` with addr 5, data 50, word → `a_ready` = 1. Next cycle `write_reg_address` = 5, `write_data` = 50, `write_word_enable` = 1. The cycle after, both enables are 0 and `register_array` reg 5 reads 50.
- **Tie:** A holds addr 1, data 2048, word; B holds addr 9, data 0xFFFFFFF6, byte; both valid.
  - A is granted first. B is granted next cycle, with `write_byte_enable` = 1.
  - A second tie is granted to A again: `prio` returned to PRIO_A after B's tie grant.
- **Scoreboard:** reserve addr 4, `rd1_addr` = 4 → `rd1_pending` = 1. B writes addr 4, data 12, byte → pending clears on the edge that ends the write cycle. Repeat with a new reserve of addr 4 on that same edge → stays 1, `reserve_err` = 0.
- **Double reserve:** reserve addr 9 twice in consecutive cycles with no write → `reserve_err` = 1 for exactly one cycle.
- **Hold and reset mid-burst:** both valid continuously.
  - `hold` = 1 → no readies, enables 0 the following cycle.
  - Release `hold`, then drop `rst` during a write cycle → enables fall at once, `pending` cleared, and the first grant after release goes to A.

Source files
------------

// File: rtl/regfile_write_scheduler_pkg.sv
// regfile_pkg: shared widths and enumerations for the register-file write
// scheduler (arbiter, output register and pending-write scoreboard).
package regfile_pkg;

  localparam int REG_NUM    = 32;
  localparam int REG_WIDTH  = 32;
  localparam int ADDR_WIDTH = 5;

  // Round-robin pointer: the named requester wins when both are valid.
  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  // Kind of write currently presented to register_array.
  typedef enum logic [1:0] {
    WR_NONE = 2'd0,
    WR_WORD = 2'd1,
    WR_BYTE = 2'd2
  } wr_kind_t;

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// regfile_write_scheduler_if: one write-back requester port.
//   valid   : requester has a write pending (master -> slave)
//   ready   : grant (slave -> master)
//   addr    : destination register
//   data    : write data
//   is_byte : 1 = byte write, 0 = word write
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. ready never depends on ready; it may depend on valid. While valid is
// high and the transfer has not happened, the master keeps addr, data and
// is_byte stable.
interface regfile_write_scheduler_if
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = REG_WIDTH
);

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              is_byte;

  modport master (output valid, output addr, output data, output is_byte, input ready);
  modport slave  (input valid, input addr, input data, input is_byte, output ready);

endinterface

// File: rtl/regfile_write_scheduler_arb.sv
// wb_rr_arbiter: two-way round-robin arbiter for the register-file write port.
//   clk, i_rst       : clock, asynchronous active-low reset
//   i_hold           : suppresses every grant while high
//   i_a_valid/i_b_valid : requests
//   o_a_grant/o_b_grant : grants, at most one high
//   o_prio           : current priority pointer (exposed for observation)
module wb_rr_arbiter
  import regfile_pkg::*;
(
  input  logic  clk,
  input  logic  i_rst,
  input  logic  i_hold,
  input  logic  i_a_valid,
  input  logic  i_b_valid,
  output logic  o_a_grant,
  output logic  o_b_grant,
  output prio_t o_prio
);

  prio_t r_prio;
  prio_t w_prio_nxt;

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      r_prio <= PRIO_A;
    end else begin
      r_prio <= w_prio_nxt;
    end
  end

  // A lone requester is always granted and leaves the pointer alone; only a
  // tie consumes the pointer and hands priority to the loser.
  always_comb begin
    o_a_grant  = 1'b0;
    o_b_grant  = 1'b0;
    w_prio_nxt = r_prio;
    if (!i_hold) begin
      if (i_a_valid && i_b_valid) begin
        if (r_prio == PRIO_A) begin
          o_a_grant  = 1'b1;
          w_prio_nxt = PRIO_B;
        end else begin
          o_b_grant  = 1'b1;
          w_prio_nxt = PRIO_A;
        end
      end else begin
        o_a_grant = i_a_valid;
        o_b_grant = i_b_valid;
      end
    end
  end

  assign o_prio = r_prio;

endmodule

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: shares the single write port of register_array
// between an ALU write-back requester (A) and a load write-back requester (B),
// and keeps a pending-write scoreboard for read-after-write hazard checks.
//   clk, rst          : clock, asynchronous active-low reset
//   hold              : blocks new grants
//   a_if, b_if        : requester ports (valid/ready/addr/data/is_byte)
//   reserve_valid/addr: issue stage claims a destination register
//   reserve_err       : one-cycle pulse, claim hit an already-pending register
//   rd1/rd2_addr      : read addresses to check
//   rd1/rd2_pending   : combinational scoreboard lookup
//   write_*           : registered write port towards register_array
//   dbg_prio          : arbiter priority pointer
module regfile_write_scheduler
  import regfile_pkg::*;
#(
  parameter int REG_NUM    = regfile_pkg::REG_NUM,
  parameter int REG_WIDTH  = regfile_pkg::REG_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  regfile_write_scheduler_if.slave a_if,
  regfile_write_scheduler_if.slave b_if,
  input  logic                  reserve_valid,
  input  logic [ADDR_WIDTH-1:0] reserve_addr,
  output logic                  reserve_err,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  input  logic [ADDR_WIDTH-1:0] rd2_addr,
  output logic                  rd1_pending,
  output logic                  rd2_pending,
  output logic [ADDR_WIDTH-1:0] write_reg_address,
  output logic [REG_WIDTH-1:0]  write_data,
  output logic                  write_word_enable,
  output logic                  write_byte_enable,
  output prio_t                 dbg_prio
);

  logic w_a_grant;
  logic w_b_grant;
  logic w_a_hs;
  logic w_b_hs;

  wb_rr_arbiter u_arb (
    .clk       (clk),
    .i_rst     (rst),
    .i_hold    (hold),
    .i_a_valid (a_if.valid),
    .i_b_valid (b_if.valid),
    .o_a_grant (w_a_grant),
    .o_b_grant (w_b_grant),
    .o_prio    (dbg_prio)
  );

  assign a_if.ready = w_a_grant;
  assign b_if.ready = w_b_grant;
  assign w_a_hs     = a_if.valid & w_a_grant;
  assign w_b_hs     = b_if.valid & w_b_grant;

  // Output register: enables last exactly one cycle per handshake; address
  // and data hold their last value between writes.
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [REG_WIDTH-1:0]  r_wr_data;
  wr_kind_t              r_wr_kind;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_kind <= WR_NONE;
    end else if (w_a_hs) begin
      r_wr_addr <= a_if.addr;
      r_wr_data <= a_if.data;
      r_wr_kind <= a_if.is_byte ? WR_BYTE : WR_WORD;
    end else if (w_b_hs) begin
      r_wr_addr <= b_if.addr;
      r_wr_data <= b_if.data;
      r_wr_kind <= b_if.is_byte ? WR_BYTE : WR_WORD;
    end else begin
      r_wr_kind <= WR_NONE;
    end
  end

  assign write_reg_address = r_wr_addr;
  assign write_data        = r_wr_data;
  assign write_word_enable = (r_wr_kind == WR_WORD);
  assign write_byte_enable = (r_wr_kind == WR_BYTE);

  // Scoreboard. The bit of the write on the port is cleared on the same edge
  // register_array captures it; a reserve on that edge is applied after the
  // clear so it wins.
  logic [REG_NUM-1:0] r_pending;
  logic [REG_NUM-1:0] w_pending_nxt;
  logic               w_clr;
  logic               w_err_nxt;
  logic               r_reserve_err;

  always_comb begin
    w_clr         = (r_wr_kind != WR_NONE);
    w_pending_nxt = r_pending;
    if (w_clr) begin
      w_pending_nxt[r_wr_addr] = 1'b0;
    end
    if (reserve_valid) begin
      w_pending_nxt[reserve_addr] = 1'b1;
    end
    w_err_nxt = reserve_valid && r_pending[reserve_addr] &&
                !(w_clr && (r_wr_addr == reserve_addr));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending     <= '0;
      r_reserve_err <= 1'b0;
    end else begin
      r_pending     <= w_pending_nxt;
      r_reserve_err <= w_err_nxt;
    end
  end

  assign reserve_err = r_reserve_err;
  assign rd1_pending = r_pending[rd1_addr];
  assign rd2_pending = r_pending[rd2_addr];

endmodule
